// File: rtl/hazard_stall_unit.sv
// Hazard stall unit: load-use bubbles, data-memory wait hold and taken-branch flush at the ID/EX boundary.
// Define HAZARD_PERF_CNT_EN to build the saturating stall_cycles / flush_count performance counters.
module hazard_stall_unit #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int REG_ADDR_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_ID,
  input  logic [REG_ADDR_W-1:0] rs2_ID,
  input  logic                  rs1_used_ID,
  input  logic                  rs2_used_ID,
  input  logic [REG_ADDR_W-1:0] rd_EX,
  input  logic                  mem_read_EX,
  input  logic                  mem_req_MEM,
  input  logic                  mem_ready,
  input  logic                  branch_taken_EX,
  output logic                  pc_write,
  output logic                  IF_ID_write,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_bubble,
  output logic                  pipe_hold,
  output logic                  busy,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
);

  localparam int LUB = (LOAD_USE_BUBBLES < 1) ? 1 :
                       (LOAD_USE_BUBBLES > 3) ? 3 : LOAD_USE_BUBBLES;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BUBBLE   = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_bubbleCnt;
  state_t     w_nextState;
  logic [1:0] w_nextCnt;
  logic       w_luh;
  logic       w_memWait;

  // x0 is hard-wired to zero, so a load targeting it can never feed a consumer.
  assign w_luh = mem_read_EX && (rd_EX != '0) &&
                 ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                  (rs2_used_ID && (rs2_ID == rd_EX)));
  assign w_memWait = mem_req_MEM && !mem_ready;

  assign busy = rst_n && (r_state != RUN);

  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_hold    = 1'b0;
    w_nextState  = r_state;
    w_nextCnt    = r_bubbleCnt;
    // Outputs are gated by rst_n so the pipeline sees idle controls during reset.
    if (rst_n) begin
      case (r_state)
        RUN: begin
          if (w_memWait) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_hold   = 1'b1;
            w_nextState = MEM_WAIT;
          end else if (branch_taken_EX) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
          end else if (w_luh) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            if (LUB > 1) begin
              w_nextState = BUBBLE;
              w_nextCnt   = 2'(LUB - 1);
            end
          end
        end
        BUBBLE: begin
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
          if (w_memWait) begin
            pipe_hold = 1'b1;
          end else if (r_bubbleCnt <= 2'd1) begin
            w_nextState = RUN;
            w_nextCnt   = 2'd0;
          end else begin
            w_nextCnt = r_bubbleCnt - 2'd1;
          end
        end
        MEM_WAIT: begin
          if (w_memWait) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_hold   = 1'b1;
          end else begin
            w_nextState = RUN;
          end
        end
        default: begin
          w_nextState = RUN;
          w_nextCnt   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_bubbleCnt <= 2'd0;
    end else begin
      r_state     <= w_nextState;
      r_bubbleCnt <= w_nextCnt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stallCycles;
  logic [31:0] r_flushCount;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else begin
      if (!pc_write && !IF_ID_flush && (r_stallCycles != '1))
        r_stallCycles <= r_stallCycles + 32'd1;
      if (IF_ID_flush && (r_flushCount != '1))
        r_flushCount <= r_flushCount + 32'd1;
    end
  end

  assign stall_cycles = r_stallCycles;
  assign flush_count  = r_flushCount;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit: two instances (1 and 3 load-use bubbles) driven by shared
// directed and random stimulus and compared against a counting reference model.
module tb_hazard_stall_unit;

  localparam int W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  rs1Id, rs2Id, rdEx;
  logic          rs1Used, rs2Used, memReadEx, memReqMem, memReady, branchTaken;
  logic [1:0]    pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeHold, busy;
  logic [31:0]   stallCycles [2];
  logic [31:0]   flushCount  [2];

  hazard_stall_unit #(.LOAD_USE_BUBBLES(1), .REG_ADDR_W(W)) dutA (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1Id), .rs2_ID(rs2Id), .rs1_used_ID(rs1Used), .rs2_used_ID(rs2Used),
    .rd_EX(rdEx), .mem_read_EX(memReadEx), .mem_req_MEM(memReqMem), .mem_ready(memReady),
    .branch_taken_EX(branchTaken),
    .pc_write(pcWrite[0]), .IF_ID_write(ifIdWrite[0]), .IF_ID_flush(ifIdFlush[0]),
    .ID_EX_bubble(idExBubble[0]), .pipe_hold(pipeHold[0]), .busy(busy[0]),
    .stall_cycles(stallCycles[0]), .flush_count(flushCount[0])
  );

  hazard_stall_unit #(.LOAD_USE_BUBBLES(3), .REG_ADDR_W(W)) dutB (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1Id), .rs2_ID(rs2Id), .rs1_used_ID(rs1Used), .rs2_used_ID(rs2Used),
    .rd_EX(rdEx), .mem_read_EX(memReadEx), .mem_req_MEM(memReqMem), .mem_ready(memReady),
    .branch_taken_EX(branchTaken),
    .pc_write(pcWrite[1]), .IF_ID_write(ifIdWrite[1]), .IF_ID_flush(ifIdFlush[1]),
    .ID_EX_bubble(idExBubble[1]), .pipe_hold(pipeHold[1]), .busy(busy[1]),
    .stall_cycles(stallCycles[1]), .flush_count(flushCount[1])
  );

  // Reference model: bubbles still owed after the current one, and whether memory is holding us.
  int     bubblesLeft [2];
  bit     waiting     [2];
  longint stallModel  [2];
  longint flushModel  [2];
  int     nBubbles    [2];
  bit     nWaiting    [2];
  bit     ePc [2], eIfw [2], eFlush [2], eBub [2], eHold [2], eBusy [2];

  int checks = 0;
  int passes = 0;

  function automatic int lubOf(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] expCnt(input longint v);
`ifdef HAZARD_PERF_CNT_EN
    return (v > 64'hFFFFFFFF) ? 32'hFFFFFFFF : v[31:0];
`else
    return (v == 64'd0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      bubblesLeft[i] = 0;
      waiting[i]     = 1'b0;
      stallModel[i]  = 0;
      flushModel[i]  = 0;
    end
  endtask

  task automatic modelEval(input int i);
    bit luh, mw;
    luh = memReadEx && (rdEx != 0) &&
          ((rs1Used && rs1Id == rdEx) || (rs2Used && rs2Id == rdEx));
    mw  = memReqMem && !memReady;
    ePc[i] = 1; eIfw[i] = 1; eFlush[i] = 0; eBub[i] = 0; eHold[i] = 0;
    eBusy[i]    = waiting[i] || (bubblesLeft[i] > 0);
    nWaiting[i] = waiting[i];
    nBubbles[i] = bubblesLeft[i];
    if (waiting[i]) begin
      if (mw) begin ePc[i] = 0; eIfw[i] = 0; eHold[i] = 1; end
      nWaiting[i] = mw;
    end else if (bubblesLeft[i] > 0) begin
      ePc[i] = 0; eIfw[i] = 0; eBub[i] = 1;
      if (mw) eHold[i] = 1;
      else nBubbles[i] = bubblesLeft[i] - 1;
    end else if (mw) begin
      ePc[i] = 0; eIfw[i] = 0; eHold[i] = 1; nWaiting[i] = 1;
    end else if (branchTaken) begin
      eFlush[i] = 1; eBub[i] = 1;
    end else if (luh) begin
      ePc[i] = 0; eIfw[i] = 0; eBub[i] = 1; nBubbles[i] = lubOf(i) - 1;
    end
  endtask

  task automatic checkIdle(input string when);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s_pc_write[%0d]", when, i), 32'(pcWrite[i]), 32'd1);
      checkOutput($sformatf("%s_IF_ID_write[%0d]", when, i), 32'(ifIdWrite[i]), 32'd1);
      checkOutput($sformatf("%s_IF_ID_flush[%0d]", when, i), 32'(ifIdFlush[i]), 32'd0);
      checkOutput($sformatf("%s_ID_EX_bubble[%0d]", when, i), 32'(idExBubble[i]), 32'd0);
      checkOutput($sformatf("%s_pipe_hold[%0d]", when, i), 32'(pipeHold[i]), 32'd0);
      checkOutput($sformatf("%s_busy[%0d]", when, i), 32'(busy[i]), 32'd0);
      checkOutput($sformatf("%s_stall_cycles[%0d]", when, i), stallCycles[i], 32'd0);
      checkOutput($sformatf("%s_flush_count[%0d]", when, i), flushCount[i], 32'd0);
    end
  endtask

  // Called just after a rising edge; leaves rst_n released away from any edge.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkIdle("rst_now");
    modelReset();
    @(posedge clk);
    #1;
    checkIdle("rst_held");
    #2;
    rst_n = 1'b1;
  endtask

  // Inputs must already be driven; checks this cycle's outputs, then advances one clock.
  task automatic runCycle();
    #1;
    for (int i = 0; i < 2; i++) begin
      modelEval(i);
      checkOutput($sformatf("pc_write[%0d]", i), 32'(pcWrite[i]), 32'(ePc[i]));
      checkOutput($sformatf("IF_ID_write[%0d]", i), 32'(ifIdWrite[i]), 32'(eIfw[i]));
      checkOutput($sformatf("IF_ID_flush[%0d]", i), 32'(ifIdFlush[i]), 32'(eFlush[i]));
      checkOutput($sformatf("ID_EX_bubble[%0d]", i), 32'(idExBubble[i]), 32'(eBub[i]));
      checkOutput($sformatf("pipe_hold[%0d]", i), 32'(pipeHold[i]), 32'(eHold[i]));
      checkOutput($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(eBusy[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!ePc[i] && !eFlush[i]) stallModel[i] = stallModel[i] + 1;
      if (eFlush[i]) flushModel[i] = flushModel[i] + 1;
      bubblesLeft[i] = nBubbles[i];
      waiting[i]     = nWaiting[i];
      checkOutput($sformatf("stall_cycles[%0d]", i), stallCycles[i], expCnt(stallModel[i]));
      checkOutput($sformatf("flush_count[%0d]", i), flushCount[i], expCnt(flushModel[i]));
    end
  endtask

  task automatic setInputs(input int r1, input int r2, input bit u1, input bit u2, input int rd,
                           input bit mr, input bit req, input bit rdy, input bit br);
    rs1Id = W'(r1); rs2Id = W'(r2); rs1Used = u1; rs2Used = u2; rdEx = W'(rd);
    memReadEx = mr; memReqMem = req; memReady = rdy; branchTaken = br;
  endtask

  task automatic applyStimulus();
    rs1Id       = W'($urandom_range(0, 3));
    rs2Id       = W'($urandom_range(0, 3));
    rdEx        = W'($urandom_range(0, 3));
    rs1Used     = 1'($urandom_range(0, 1));
    rs2Used     = 1'($urandom_range(0, 1));
    memReadEx   = 1'($urandom_range(0, 1));
    memReqMem   = ($urandom_range(0, 3) == 0);
    memReady    = 1'($urandom_range(0, 1));
    branchTaken = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    rst_n = 1'b1;
    setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    #2;
    // Hazard inputs during reset must not leak onto the outputs.
    setInputs(5, 5, 1, 1, 5, 1, 0, 0, 1);
    doReset();

    setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0); runCycle();
    setInputs(5, 0, 1, 0, 5, 1, 0, 0, 0); runCycle();
    for (int k = 0; k < 3; k++) begin setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0); runCycle(); end

    setInputs(0, 0, 1, 0, 0, 1, 0, 0, 0); runCycle();
    setInputs(0, 7, 0, 0, 7, 1, 0, 0, 0); runCycle();

    for (int k = 0; k < 4; k++) begin setInputs(3, 0, 1, 0, 3, 1, 1, 0, 0); runCycle(); end
    setInputs(3, 0, 1, 0, 3, 1, 1, 1, 0); runCycle();
    setInputs(3, 0, 1, 0, 3, 1, 0, 0, 0); runCycle();
    for (int k = 0; k < 3; k++) begin setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0); runCycle(); end

    setInputs(4, 4, 1, 1, 4, 1, 0, 0, 1); runCycle();
    setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0); runCycle();

    setInputs(6, 0, 1, 0, 6, 1, 0, 0, 0); runCycle();
    setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    doReset();
    for (int k = 0; k < 3; k++) begin setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0); runCycle(); end

    for (int n = 0; n < 2000; n++) begin
      applyStimulus();
      if ($urandom_range(0, 99) == 0) doReset();
      else runCycle();
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
